// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of one CPU's instruction cache.
// The slave modport is the cache's view; master is the surrounding datapath/controller.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] misscount;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, misscount
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, misscount
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache.
// Hits are served combinationally in IDLE; a miss fetches one word through FETCH.
module icache #(
  parameter int unsigned SETS = 16
) (
  input logic      CLK,
  input logic      nRST,
  icache_if.slave  bus
);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 30 - IW;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   reqaddr_q, reqaddr_d;
  logic [31:0]   misscount_q, misscount_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q  [SETS];
  logic [31:0]   data_q [SETS];

  logic [IW-1:0] idx, fill_idx;
  logic [TW-1:0] tag;
  logic          hit, fill;

  assign idx      = bus.imemaddr[IW+1:2];
  assign tag      = bus.imemaddr[31:IW+2];
  assign fill_idx = reqaddr_q[IW+1:2];

  // Hit is gated by IDLE so a frame being filled is never forwarded.
  assign hit  = bus.imemREN && (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
  assign fill = (state_q == FETCH) && !bus.iwait;

  always_comb begin
    state_d     = state_q;
    reqaddr_d   = reqaddr_q;
    misscount_d = misscount_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit) begin
          reqaddr_d = bus.imemaddr & 32'hFFFF_FFFC;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (!bus.iwait) begin
          valid_d[fill_idx] = 1'b1;
          misscount_d       = misscount_q + 32'd1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides a coinciding fill; the completed fill still counts.
    if (bus.flush) valid_d = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      reqaddr_q   <= '0;
      misscount_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      reqaddr_q   <= reqaddr_d;
      misscount_q <= misscount_d;
      valid_q     <= valid_d;
    end
  end

  // Tag/data need no reset: valid bits qualify them, and fill is low while in reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= reqaddr_q[31:IW+2];
      data_q[fill_idx] <= bus.iload;
    end
  end

  always_comb begin
    bus.ihit      = hit;
    bus.imemload  = hit ? data_q[idx] : 32'd0;
    bus.iREN      = (state_q == FETCH);
    bus.iaddr     = (state_q == FETCH) ? reqaddr_q : 32'd0;
    bus.misscount = misscount_q;
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a cycle table for the basic miss/hit flow, then
// hand sequences for conflict, redirect, flush-on-fill and reset-in-FETCH.
module tb_icache;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  icache_if bus ();

  icache #(.SETS(16)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_mc = 32'd0;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        iwait;
    logic [31:0] iload;
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] mc;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic iw,
                       input logic [31:0] ld, input logic fl);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.iwait    = iw;
    bus.iload    = ld;
    bus.flush    = fl;
  endtask

  // Miss on addr, controller stalls nwait cycles, then the next IDLE cycle must hit.
  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] data, input int nwait);
    drive(1'b1, addr, 1'b1, data, 1'b0);
    #1;
    chk1("mf_miss", bus.ihit, 1'b0);
    chk1("mf_idle_iren", bus.iREN, 1'b0);
    step();
    for (int i = 0; i < nwait; i++) begin
      chk1("mf_wait_iren", bus.iREN, 1'b1);
      chk("mf_wait_iaddr", bus.iaddr, addr & 32'hFFFF_FFFC);
      chk1("mf_wait_nohit", bus.ihit, 1'b0);
      step();
    end
    bus.iwait = 1'b0;
    #1;
    chk1("mf_fill_iren", bus.iREN, 1'b1);
    chk("mf_fill_iaddr", bus.iaddr, addr & 32'hFFFF_FFFC);
    step();
    exp_mc++;
    bus.iwait = 1'b1;
    #1;
    chk1("mf_hit", bus.ihit, 1'b1);
    chk("mf_data", bus.imemload, data);
    chk("mf_count", bus.misscount, exp_mc);
  endtask

  initial begin
    nrst = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
    #1 nrst = 1'b0;
    #1;
    chk1("rst_ihit", bus.ihit, 1'b0);
    chk("rst_load", bus.imemload, 32'd0);
    chk1("rst_iren", bus.iREN, 1'b0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    chk("rst_count", bus.misscount, 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    //          ren  addr           iwait iload          ihit load          iren iaddr         mc
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h2001_000A, 1'b0, 32'h0,         1'b0, 32'h0,  32'd0};
    vecs[1]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h2001_000A, 1'b0, 32'h0,         1'b1, 32'h0,  32'd0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h2001_000A, 1'b0, 32'h0,         1'b1, 32'h0,  32'd0};
    vecs[3]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h2001_000A, 1'b0, 32'h0,         1'b1, 32'h0,  32'd0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h2001_000A, 1'b0, 32'h0,         1'b1, 32'h0,  32'd0};
    vecs[5]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h2001_000A, 1'b1, 32'h2001_000A, 1'b0, 32'h0,  32'd1};
    vecs[6]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,         1'b1, 32'h2001_000A, 1'b0, 32'h0,  32'd1};
    vecs[7]  = '{1'b1, 32'h0000_0042, 1'b0, 32'hDEAD_0042, 1'b0, 32'h0,         1'b0, 32'h0,  32'd1};
    vecs[8]  = '{1'b1, 32'h0000_0042, 1'b0, 32'hDEAD_0042, 1'b0, 32'h0,         1'b1, 32'h40, 32'd1};
    vecs[9]  = '{1'b1, 32'h0000_0042, 1'b1, 32'h0,         1'b1, 32'hDEAD_0042, 1'b0, 32'h0,  32'd2};
    vecs[10] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'hDEAD_0042, 1'b0, 32'h0,  32'd2};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ren, vecs[i].addr, vecs[i].iwait, vecs[i].iload, 1'b0);
      #1;
      chk1($sformatf("vec%0d_ihit", i), bus.ihit, vecs[i].ihit);
      chk($sformatf("vec%0d_load", i), bus.imemload, vecs[i].load);
      chk1($sformatf("vec%0d_iren", i), bus.iREN, vecs[i].iren);
      chk($sformatf("vec%0d_iaddr", i), bus.iaddr, vecs[i].iaddr);
      chk($sformatf("vec%0d_count", i), bus.misscount, vecs[i].mc);
      step();
    end
    exp_mc = 32'd2;

    // Conflict on index 1: 0x04 and 0x44 evict each other.
    miss_fill(32'h0000_0004, 32'h1111_0004, 0);
    miss_fill(32'h0000_0044, 32'h2222_0044, 1);
    miss_fill(32'h0000_0004, 32'h3333_0004, 0);
    chk("conflict_count", bus.misscount, 32'd5);
    bus.imemaddr = 32'h0000_0044;
    #1;
    chk1("conflict_evicted", bus.ihit, 1'b0);
    bus.imemREN = 1'b0;
    step();

    // Redirect and imemREN drop during FETCH must not disturb the fill of 0x100.
    drive(1'b1, 32'h0000_0100, 1'b1, 32'hAAAA_0100, 1'b0);
    #1;
    chk1("redir_miss", bus.ihit, 1'b0);
    step();
    bus.imemaddr = 32'h0000_0200;
    bus.imemREN  = 1'b0;
    #1;
    chk1("redir_iren", bus.iREN, 1'b1);
    chk("redir_iaddr_wait", bus.iaddr, 32'h0000_0100);
    step();
    bus.iwait = 1'b0;
    #1;
    chk("redir_iaddr_fill", bus.iaddr, 32'h0000_0100);
    step();
    exp_mc++;
    bus.iwait   = 1'b1;
    bus.imemREN = 1'b1;
    #1;
    chk1("redir_new_miss", bus.ihit, 1'b0);
    chk("redir_count", bus.misscount, exp_mc);
    bus.imemaddr = 32'h0000_0100;
    #1;
    chk1("redir_old_hit", bus.ihit, 1'b1);
    chk("redir_old_data", bus.imemload, 32'hAAAA_0100);
    step();

    // Flush on the fill-completion edge of 0x8.
    drive(1'b1, 32'h0000_0008, 1'b1, 32'hBBBB_0008, 1'b0);
    #1;
    chk1("flfill_miss", bus.ihit, 1'b0);
    step();
    bus.iwait = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk1("flfill_iren", bus.iREN, 1'b1);
    step();
    exp_mc++;
    bus.flush = 1'b0;
    bus.iwait = 1'b1;
    #1;
    chk("flfill_count1", bus.misscount, exp_mc);
    chk1("flfill_remiss", bus.ihit, 1'b0);
    step();
    bus.iwait = 1'b0;
    #1;
    chk("flfill_iaddr", bus.iaddr, 32'h0000_0008);
    step();
    exp_mc++;
    bus.iwait = 1'b1;
    #1;
    chk1("flfill_hit", bus.ihit, 1'b1);
    chk("flfill_data", bus.imemload, 32'hBBBB_0008);
    chk("flfill_count2", bus.misscount, exp_mc);

    // Flush in IDLE: this cycle still hits on pre-flush state, next cycle misses.
    bus.flush = 1'b1;
    #1;
    chk1("flidle_prehit", bus.ihit, 1'b1);
    step();
    bus.flush = 1'b0;
    #1;
    chk1("flidle_post8", bus.ihit, 1'b0);
    bus.imemaddr = 32'h0000_0100;
    #1;
    chk1("flidle_post100", bus.ihit, 1'b0);
    bus.imemREN = 1'b0;
    step();

    // Reset in the middle of FETCH.
    drive(1'b1, 32'h0000_0300, 1'b1, 32'hCCCC_0300, 1'b0);
    #1;
    chk1("rstf_miss", bus.ihit, 1'b0);
    step();
    chk1("rstf_iren_pre", bus.iREN, 1'b1);
    nrst = 1'b0;
    #1;
    chk1("rstf_iren", bus.iREN, 1'b0);
    chk("rstf_iaddr", bus.iaddr, 32'd0);
    chk("rstf_count", bus.misscount, 32'd0);
    chk1("rstf_ihit", bus.ihit, 1'b0);
    exp_mc = 32'd0;
    step();
    step();
    nrst = 1'b1;
    miss_fill(32'h0000_0300, 32'hCCCC_0300, 2);
    chk("rstf_final_count", bus.misscount, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
